game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
- Central game-flow controller for the Flappy Bird top level.
- Derives a one-cycle frame tick from the VGA vertical sync.
- Sequences the game through idle, get-ready, play, dying and game-over.
- Converts the raw USB keycode into debounced, frame-aligned flap requests.
- Owns the BCD current and high scores.
- Gates the bird and pipe movers (run, game_end) and feeds the HEX score drivers.

Parameters:
- FLAP_KEY, 8'h2C, keycode that flaps or starts the game (space bar).
- READY_FRAMES, 8'd90, frame ticks spent in READY before play starts.
- DEATH_FRAMES, 8'd60, frame ticks spent in DYING before OVER.

Ports:
- Clk  input  1  system clock (50 MHz, same domain as vga_controller).
- Reset_n  input  1  asynchronous active-low reset.
- vs  input  1  VGA vertical sync from vga_controller, synchronous to Clk.
- keycode  input  8  current USB keycode, 8'h00 when no key is held.
- collision  input  1  level, bird overlaps a pipe or the floor/ceiling.
- pipe_pass  input  1  one-cycle pulse when the bird clears a pipe pair.
- state  output  3  IDLE=0, READY=1, PLAY=2, DYING=3, OVER=4.
- frame_tick  output  1  one-cycle pulse per frame.
- flap  output  1  one-cycle flap request, coincident with frame_tick.
- run  output  1  pipes scroll; high only in PLAY.
- bird_en  output  1  bird physics enabled; high in READY, PLAY and DYING.
- game_end  output  1  high in DYING and OVER.
- score  output  8  BCD current score, [7:4] tens, [3:0] units.
- high_score  output  8  BCD high score.
- new_high  output  1  high in OVER when the last game set a new high score.

Behaviour:
- Reset (async assert on Reset_n low, sync release):
  - state=IDLE, frame counter=0, pending flap=0, vs_d=0, key_d=0.
  - All outputs 0; high_score=0.
- Frame tick:
  - vs_d is a registered copy of vs.
  - frame_tick is registered (vs & ~vs_d), so it pulses the cycle after the first high sample of vs.
  - Exactly one pulse per vs rising edge.
- Key edge:
  - press = (keycode==FLAP_KEY) & ~key_d, where key_d = registered (keycode==FLAP_KEY).
  - A held key produces one press only.
- Flap:
  - In PLAY, a press sets pending. On the next frame_tick, flap=1 for that cycle and pending clears.
  - Any number of presses within one frame yields one flap.
  - A press in the same cycle as frame_tick is emitted on that tick.
  - pending is cleared on every state exit.
- FSM (registered; outputs decoded from state):
  - IDLE: press -> READY; score cleared to 00; frame counter cleared.
  - READY: count frame_ticks; when count reaches READY_FRAMES-1 on a tick -> PLAY, counter cleared. Presses are ignored for flap.
  - PLAY:
    - collision=1 -> DYING (next cycle), counter cleared.
    - pipe_pass=1 with collision=0 -> score increments.
    - pipe_pass together with collision: collision wins, no increment.
  - DYING: count frame_ticks; at DEATH_FRAMES-1 -> OVER. collision and pipe_pass are ignored.
  - OVER:
    - On entry, if score > high_score (plain 8-bit compare, valid for BCD): high_score<=score and new_high<=1.
    - press -> READY; score cleared; new_high cleared.
  - Illegal encodings -> IDLE.
- Score arithmetic:
  - BCD increment: units 9 -> 0 with tens+1.
  - Saturates at 8'h99; a further pipe_pass holds 99.
  - Increment takes effect the cycle after pipe_pass.
- Reset mid-game returns immediately to IDLE with score 0; high_score is lost.

Test Plan:
- Reset, then toggle vs with period 1000 cycles -> exactly one frame_tick per rising edge, 1 cycle after vs high; state=0 and all outputs 0 until a key arrives.
- keycode=8'h2C held 500 cycles in IDLE -> single transition to READY; with READY_FRAMES=3, state=PLAY after the 3rd tick, run=1, bird_en=1.
- In PLAY, three presses of 8'h2C between two ticks -> exactly one flap pulse, coincident with the next frame_tick; no flap on the tick after that.
- Apply 12 pipe_pass pulses in PLAY -> score=8'h12. Preload via 99 passes, then one more -> score stays 8'h99.
- In PLAY, pipe_pass and collision in the same cycle -> score unchanged, state=DYING next cycle, game_end=1. After DEATH_FRAMES ticks -> state=OVER, high_score=score, new_high=1.
- In OVER, press -> READY with score=00 and high_score retained; drop Reset_n low mid-PLAY -> state=IDLE and high_score=00 immediately, asynchronously.

Source files
------------

// File: rtl/game_sequencer.sv
// Flappy Bird game-flow controller: frame tick from vsync, edge-detected flap requests,
// game state machine and BCD score / high-score tracking.
module game_sequencer #(
    parameter logic [7:0] FLAP_KEY     = 8'h2C,
    parameter logic [7:0] READY_FRAMES = 8'd90,
    parameter logic [7:0] DEATH_FRAMES = 8'd60
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       vs,
    input  logic [7:0] keycode,
    input  logic       collision,
    input  logic       pipe_pass,
    output logic [2:0] state,
    output logic       frame_tick,
    output logic       flap,
    output logic       run,
    output logic       bird_en,
    output logic       game_end,
    output logic [7:0] score,
    output logic [7:0] high_score,
    output logic       new_high
);
    // state | meaning
    // IDLE  | attract screen, waiting for the first press
    // READY | get-ready countdown, bird live, pipes frozen
    // PLAY  | pipes scroll, flaps and scoring live
    // DYING | death animation, collision/pipe_pass ignored
    // OVER  | final score shown, a press starts a new game
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READY = 3'd1,
        S_PLAY  = 3'd2,
        S_DYING = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic       vs_d, key_d;
    logic       pending_q, pending_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] score_q, score_d;
    logic [7:0] high_q, high_d;
    logic       new_high_q, new_high_d;
    logic       key_hit, press;

    assign key_hit = (keycode == FLAP_KEY);
    assign press   = key_hit & ~key_d;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99)
            r = v;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= S_IDLE;
            vs_d       <= 1'b0;
            frame_tick <= 1'b0;
            key_d      <= 1'b0;
            pending_q  <= 1'b0;
            cnt_q      <= 8'd0;
            score_q    <= 8'h00;
            high_q     <= 8'h00;
            new_high_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            vs_d       <= vs;
            frame_tick <= vs & ~vs_d;
            key_d      <= key_hit;
            pending_q  <= pending_d;
            cnt_q      <= cnt_d;
            score_q    <= score_d;
            high_q     <= high_d;
            new_high_q <= new_high_d;
        end
    end

    // Frame counts are down-counters loaded with N-1 on entry; terminal count is zero.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        cnt_d      = cnt_q;
        score_d    = score_q;
        high_d     = high_q;
        new_high_d = new_high_q;
        flap       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (press) begin
                    state_d = S_READY;
                    score_d = 8'h00;
                    cnt_d   = READY_FRAMES - 8'd1;
                end
            end
            S_READY: begin
                if (frame_tick) begin
                    if (cnt_q == 8'd0) begin
                        state_d = S_PLAY;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            S_PLAY: begin
                // A press landing on the tick itself is served immediately.
                flap = frame_tick & (pending_q | press);
                if (frame_tick)
                    pending_d = 1'b0;
                else if (press)
                    pending_d = 1'b1;
                if (collision) begin
                    state_d = S_DYING;
                    cnt_d   = DEATH_FRAMES - 8'd1;
                end else if (pipe_pass) begin
                    score_d = bcd_inc(score_q);
                end
            end
            S_DYING: begin
                if (frame_tick) begin
                    if (cnt_q == 8'd0) begin
                        state_d = S_OVER;
                        if (score_q > high_q) begin
                            high_d     = score_q;
                            new_high_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            S_OVER: begin
                if (press) begin
                    state_d    = S_READY;
                    score_d    = 8'h00;
                    new_high_d = 1'b0;
                    cnt_d      = READY_FRAMES - 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (state_d != state_q)
            pending_d = 1'b0;
    end

    assign state      = state_q;
    assign run        = (state_q == S_PLAY);
    assign bird_en    = (state_q == S_READY) | (state_q == S_PLAY) | (state_q == S_DYING);
    assign game_end   = (state_q == S_DYING) | (state_q == S_OVER);
    assign score      = score_q;
    assign high_score = high_q;
    assign new_high   = new_high_q;
endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed and randomized key / pipe / collision traffic,
// compared every cycle against a rule-level reference model of the game.
module tb_game_sequencer;
    localparam logic [7:0] KEY = 8'h2C;
    localparam int RF = 3;
    localparam int DF = 4;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       vs = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic       collision = 1'b0;
    logic       pipe_pass = 1'b0;
    logic [2:0] state;
    logic       frame_tick, flap, run, bird_en, game_end, new_high;
    logic [7:0] score, high_score;
    logic [24:0] dut_vec;

    int vs_half = 500;
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int vs_rises[$];

    typedef struct packed {
        int st;
        int cnt;
        int score;
        int high;
        bit nh;
        bit pend;
        bit tick;
        bit vs_d;
        bit key_d;
    } model_t;
    model_t m;

    game_sequencer #(.FLAP_KEY(KEY), .READY_FRAMES(8'd3), .DEATH_FRAMES(8'd4)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .vs(vs), .keycode(keycode),
        .collision(collision), .pipe_pass(pipe_pass), .state(state),
        .frame_tick(frame_tick), .flap(flap), .run(run), .bird_en(bird_en),
        .game_end(game_end), .score(score), .high_score(high_score), .new_high(new_high)
    );

    assign dut_vec = {state, frame_tick, flap, run, bird_en, game_end, score, high_score, new_high};

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    initial forever begin
        repeat (vs_half) @(negedge Clk);
        vs = ~vs;
        if (vs) vs_rises.push_back(cyc);
    end

    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) << 4) + (v % 10));
    endfunction

    // Score is kept as a plain integer; BCD only appears when comparing.
    function automatic model_t model_step(input model_t c, input logic [7:0] kc,
                                          input bit v, input bit col, input bit pp);
        model_t n = c;
        bit press = (kc == KEY) && !c.key_d;
        case (c.st)
            0: if (press) begin n.st = 1; n.score = 0; n.cnt = 0; end
            1: if (c.tick) begin
                   if (c.cnt == RF - 1) begin n.st = 2; n.cnt = 0; end
                   else n.cnt = c.cnt + 1;
               end
            2: if (col) begin n.st = 3; n.cnt = 0; end
               else if (pp && c.score < 99) n.score = c.score + 1;
            3: if (c.tick) begin
                   if (c.cnt == DF - 1) begin
                       n.st = 4;
                       if (c.score > c.high) begin n.high = c.score; n.nh = 1'b1; end
                   end else n.cnt = c.cnt + 1;
               end
            4: if (press) begin n.st = 1; n.score = 0; n.nh = 1'b0; n.cnt = 0; end
            default: n.st = 0;
        endcase
        if (n.st != c.st) n.pend = 1'b0;
        else if (c.st == 2) n.pend = c.tick ? 1'b0 : (press ? 1'b1 : c.pend);
        n.tick  = v && !c.vs_d;
        n.vs_d  = v;
        n.key_d = (kc == KEY);
        return n;
    endfunction

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) m <= '0;
        else m <= model_step(m, keycode, vs, collision, pipe_pass);
    end

    function automatic logic [24:0] exp_vec();
        bit fl = (m.st == 2) && m.tick && (m.pend || ((keycode == KEY) && !m.key_d));
        return {3'(m.st), m.tick, fl, m.st == 2, (m.st >= 1) && (m.st <= 3), m.st >= 3,
                bcd(m.score), bcd(m.high), m.nh};
    endfunction

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (3) @(negedge Clk);
        n_chk++;
        if (dut_vec !== 25'd0) begin n_fail++; $display("FAIL reset_outputs: got %h, expected 0", dut_vec); end
        Reset_n = 1'b1;
    endtask

    task automatic test_frame_tick();
        int ticks[$];
        bit ok, hit;
        for (int i = 0; i < 2200; i++) begin
            @(negedge Clk);
            n_chk++;
            if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL frame_cycle cyc=%0d: got %h, expected %h", cyc, dut_vec, exp_vec()); end
            if (frame_tick) ticks.push_back(cyc);
        end
        ok = (ticks.size() == 2);
        foreach (ticks[k]) begin
            hit = 1'b0;
            foreach (vs_rises[j]) if (vs_rises[j] + 1 == ticks[k]) hit = 1'b1;
            ok = ok && hit;
        end
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL frame_tick_timing: got %0d ticks, expected 2 each one cycle after a vs rise", ticks.size()); end
    endtask

    task automatic test_start();
        int entries = 0;
        logic [2:0] prev = state;
        vs_half = 10;
        keycode = KEY;
        for (int i = 0; i < 500; i++) begin
            @(negedge Clk);
            n_chk++;
            if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL start_cycle cyc=%0d: got %h, expected %h", cyc, dut_vec, exp_vec()); end
            if (prev == 3'd0 && state == 3'd1) entries++;
            prev = state;
        end
        keycode = 8'h00;
        n_chk++;
        if (entries != 1 || state !== 3'd2 || run !== 1'b1 || bird_en !== 1'b1) begin
            n_fail++; $display("FAIL start_to_play: got entries=%0d state=%0d run=%b bird_en=%b, expected 1 2 1 1", entries, state, run, bird_en);
        end
    endtask

    task automatic test_flap();
        int flaps = 0;
        int ticks = 0;
        bit seen = 1'b0;
        logic f1 = 1'b0, f2 = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge Clk);
            n_chk++;
            if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL flap_sync cyc=%0d: got %h, expected %h", cyc, dut_vec, exp_vec()); end
            seen = frame_tick;
        end
        n_chk++;
        if (!seen) begin n_fail++; $display("FAIL flap_sync_timeout: got no frame_tick, expected one within 100 cycles"); end
        for (int p = 0; p < 3; p++) begin
            keycode = KEY;
            @(negedge Clk);
            n_chk++;
            if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL flap_press cyc=%0d: got %h, expected %h", cyc, dut_vec, exp_vec()); end
            flaps += int'(flap);
            keycode = 8'h00;
            repeat ($urandom_range(1, 2)) begin
                @(negedge Clk);
                n_chk++;
                if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL flap_release cyc=%0d: got %h, expected %h", cyc, dut_vec, exp_vec()); end
                flaps += int'(flap);
            end
        end
        for (int i = 0; i < 60 && ticks < 2; i++) begin
            @(negedge Clk);
            n_chk++;
            if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL flap_wait cyc=%0d: got %h, expected %h", cyc, dut_vec, exp_vec()); end
            flaps += int'(flap);
            if (frame_tick) begin
                ticks++;
                if (ticks == 1) f1 = flap; else f2 = flap;
            end
        end
        n_chk++;
        if (ticks != 2 || f1 !== 1'b1 || f2 !== 1'b0 || flaps != 1) begin
            n_fail++; $display("FAIL flap_once: got ticks=%0d flap@tick1=%b flap@tick2=%b flaps=%0d, expected 2 1 0 1", ticks, f1, f2, flaps);
        end
        repeat (19) begin
            @(negedge Clk);
            n_chk++;
            if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL flap_gap cyc=%0d: got %h, expected %h", cyc, dut_vec, exp_vec()); end
        end
        keycode = KEY;
        @(negedge Clk);
        n_chk++;
        if (frame_tick !== 1'b1 || flap !== 1'b1) begin
            n_fail++; $display("FAIL flap_same_cycle: got frame_tick=%b flap=%b, expected 1 1", frame_tick, flap);
        end
        keycode = 8'h00;
        for (int i = 0; i < 400; i++) begin
            @(negedge Clk);
            n_chk++;
            if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL flap_random cyc=%0d: got %h, expected %h", cyc, dut_vec, exp_vec()); end
            keycode = ($urandom_range(0, 2) == 0) ? KEY : 8'($urandom_range(0, 255));
        end
        keycode = 8'h00;
    endtask

    task automatic test_score_count();
        for (int p = 0; p < 12; p++) begin
            pipe_pass = 1'b1;
            @(negedge Clk);
            n_chk++;
            if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL score_pulse cyc=%0d: got %h, expected %h", cyc, dut_vec, exp_vec()); end
            pipe_pass = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge Clk);
        end
        n_chk++;
        if (score !== 8'h12) begin n_fail++; $display("FAIL score_12: got %h, expected 12", score); end
    endtask

    task automatic test_collision();
        pipe_pass = 1'b1;
        collision = 1'b1;
        @(negedge Clk);
        n_chk++;
        if (state !== 3'd3 || game_end !== 1'b1 || run !== 1'b0 || score !== 8'h12) begin
            n_fail++; $display("FAIL collision_wins: got state=%0d game_end=%b run=%b score=%h, expected 3 1 0 12", state, game_end, run, score);
        end
        for (int i = 0; i < 200 && state !== 3'd4; i++) begin
            collision = 1'($urandom_range(0, 1));
            pipe_pass = 1'($urandom_range(0, 1));
            @(negedge Clk);
            n_chk++;
            if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL dying_cycle cyc=%0d: got %h, expected %h", cyc, dut_vec, exp_vec()); end
        end
        collision = 1'b0;
        pipe_pass = 1'b0;
        n_chk++;
        if (state !== 3'd4 || high_score !== 8'h12 || new_high !== 1'b1 || bird_en !== 1'b0) begin
            n_fail++; $display("FAIL dying_to_over: got state=%0d high=%h new_high=%b bird_en=%b, expected 4 12 1 0", state, high_score, new_high, bird_en);
        end
    endtask

    task automatic test_restart_saturate();
        keycode = KEY;
        @(negedge Clk);
        keycode = 8'h00;
        n_chk++;
        if (state !== 3'd1 || score !== 8'h00 || high_score !== 8'h12 || new_high !== 1'b0) begin
            n_fail++; $display("FAIL over_restart: got state=%0d score=%h high=%h new_high=%b, expected 1 00 12 0", state, score, high_score, new_high);
        end
        for (int i = 0; i < 200 && state !== 3'd2; i++) begin
            @(negedge Clk);
            n_chk++;
            if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL ready_cycle cyc=%0d: got %h, expected %h", cyc, dut_vec, exp_vec()); end
            keycode = ($urandom_range(0, 1) == 1) ? KEY : 8'h00;
        end
        keycode = 8'h00;
        for (int p = 0; p < 100; p++) begin
            pipe_pass = 1'b1;
            @(negedge Clk);
            n_chk++;
            if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL sat_cycle cyc=%0d: got %h, expected %h", cyc, dut_vec, exp_vec()); end
            if (p == 98) begin
                n_chk++;
                if (score !== 8'h99) begin n_fail++; $display("FAIL score_reach_99: got %h, expected 99", score); end
            end
        end
        pipe_pass = 1'b0;
        n_chk++;
        if (score !== 8'h99) begin n_fail++; $display("FAIL score_saturate: got %h, expected 99", score); end
        collision = 1'b1;
        @(negedge Clk);
        collision = 1'b0;
        for (int i = 0; i < 200 && state !== 3'd4; i++) begin
            @(negedge Clk);
            n_chk++;
            if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL sat_dying cyc=%0d: got %h, expected %h", cyc, dut_vec, exp_vec()); end
        end
        n_chk++;
        if (state !== 3'd4 || high_score !== 8'h99 || new_high !== 1'b1) begin
            n_fail++; $display("FAIL high_99: got state=%0d high=%h new_high=%b, expected 4 99 1", state, high_score, new_high);
        end
    endtask

    task automatic test_no_new_high();
        keycode = KEY;
        @(negedge Clk);
        keycode = 8'h00;
        for (int i = 0; i < 200 && state !== 3'd2; i++) @(negedge Clk);
        for (int i = 0; i < 12; i++) begin
            pipe_pass = 1'($urandom_range(0, 1));
            @(negedge Clk);
            n_chk++;
            if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL low_play cyc=%0d: got %h, expected %h", cyc, dut_vec, exp_vec()); end
        end
        pipe_pass = 1'b0;
        collision = 1'b1;
        @(negedge Clk);
        collision = 1'b0;
        for (int i = 0; i < 200 && state !== 3'd4; i++) @(negedge Clk);
        n_chk++;
        if (state !== 3'd4 || high_score !== 8'h99 || new_high !== 1'b0) begin
            n_fail++; $display("FAIL no_new_high: got state=%0d high=%h new_high=%b, expected 4 99 0", state, high_score, new_high);
        end
    endtask

    task automatic test_reset_mid_play();
        keycode = KEY;
        @(negedge Clk);
        keycode = 8'h00;
        for (int i = 0; i < 200 && state !== 3'd2; i++) @(negedge Clk);
        pipe_pass = 1'b1;
        @(negedge Clk);
        pipe_pass = 1'b0;
        #2 Reset_n = 1'b0;
        #1;
        n_chk++;
        if (state !== 3'd0 || high_score !== 8'h00 || score !== 8'h00 || run !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got state=%0d high=%h score=%h run=%b, expected 0 00 00 0", state, high_score, score, run);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            n_chk++;
            if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL post_reset cyc=%0d: got %h, expected %h", cyc, dut_vec, exp_vec()); end
        end
    endtask

    initial begin
        test_reset();
        test_frame_tick();
        test_start();
        test_flap();
        test_score_count();
        test_collision();
        test_restart_saturate();
        test_no_new_high();
        test_reset_mid_play();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
